credit_bank: RTL

Credit ledger for the slot machine, sitting directly downstream of the top-level reel FSM. It charges a bet when a spin is accepted and captures the four settled hex digits when the reels stop. It scores the match and pays out the winnings into a saturating credit register, one credit per oclk cycle, so the count visibly ramps. It also blocks further play when credits are exhausted.

---
 rtl/credit_bank.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/credit_bank.sv
// Credit ledger for the slot machine: charges a bet per accepted spin, scores the
// settled reel digits and ramps winnings into a saturating balance, one credit per cycle.
module credit_bank #(
  parameter int CREDIT_W      = 10,
  parameter int START_CREDITS = 20,
  parameter int BET           = 1,
  parameter int PAYOUT_4      = 16,
  parameter int PAYOUT_3      = 2
) (
  input  logic                oclk,
  input  logic                RST,
  input  logic                EIN,
  input  logic                spin_start,
  input  logic                settle,
  input  logic [15:0]         digits,
  output logic [CREDIT_W-1:0] credits,
  output logic                armed,
  output logic                busy,
  output logic                broke,
  output logic                reject,
  output logic                win4,
  output logic                win3,
  output logic [CREDIT_W-1:0] last_payout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_EVAL  = 3'd2,
    S_PAY   = 3'd3,
    S_BROKE = 3'd4
  } state_t;

  localparam logic [CREDIT_W-1:0] C_MAX   = '1;
  localparam logic [CREDIT_W-1:0] C_ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] C_BET   = CREDIT_W'(BET);
  localparam logic [CREDIT_W-1:0] C_START = CREDIT_W'(START_CREDITS);
  localparam logic [CREDIT_W-1:0] C_PAY4  = CREDIT_W'(PAYOUT_4);
  localparam logic [CREDIT_W-1:0] C_PAY3  = CREDIT_W'(PAYOUT_3);
  localparam state_t S_RST = (START_CREDITS < BET) ? S_BROKE : S_IDLE;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [CREDIT_W-1:0] cnt_q, cnt_d;
  logic [CREDIT_W-1:0] lp_q, lp_d;
  logic [15:0]         dig_q, dig_d;
  logic                rej_q, rej_d;
  logic                w4_q, w4_d;
  logic                w3_q, w3_d;

  // Largest multiplicity among the four captured hex digits.
  logic [2:0]          mult_c, cnt_c;
  logic [CREDIT_W-1:0] payout_c;

  always_comb begin
    mult_c = '0;
    cnt_c  = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_c = '0;
      for (int j = 0; j < 4; j++)
        cnt_c = cnt_c + {2'b00, (dig_q[4*j +: 4] == dig_q[4*i +: 4])};
      if (cnt_c > mult_c) mult_c = cnt_c;
    end
    if (mult_c == 3'd4)      payout_c = C_PAY4;
    else if (mult_c == 3'd3) payout_c = C_PAY3;
    else                     payout_c = '0;
  end

  logic [CREDIT_W-1:0] inc_c;
  logic [CREDIT_W-1:0] dec_c;
  assign inc_c = credits_q + C_ONE;
  assign dec_c = cnt_q - C_ONE;

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    lp_d      = lp_q;
    rej_d     = 1'b0;
    w4_d      = 1'b0;
    w3_d      = 1'b0;
    if (EIN) begin
      case (state_q)
        S_IDLE: begin
          if (spin_start) begin
            if (credits_q >= C_BET) begin
              credits_d = credits_q - C_BET;
              state_d   = S_ARMED;
            end else begin
              rej_d   = 1'b1;
              state_d = S_BROKE;
            end
          end
        end
        S_ARMED: begin
          if (settle) begin
            dig_d   = digits;
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          lp_d  = payout_c;
          cnt_d = payout_c;
          w4_d  = (mult_c == 3'd4);
          w3_d  = (mult_c == 3'd3);
          if (payout_c != '0)        state_d = S_PAY;
          else if (credits_q < C_BET) state_d = S_BROKE;
          else                        state_d = S_IDLE;
        end
        S_PAY: begin
          // Already saturated (or nothing left): forfeit the remainder without adding.
          if (credits_q == C_MAX || cnt_q == '0) begin
            cnt_d   = '0;
            state_d = (credits_q < C_BET) ? S_BROKE : S_IDLE;
          end else begin
            credits_d = inc_c;
            cnt_d     = dec_c;
            if (dec_c == '0 || inc_c == C_MAX) begin
              cnt_d   = '0;
              state_d = (inc_c < C_BET) ? S_BROKE : S_IDLE;
            end
          end
        end
        S_BROKE: rej_d = spin_start;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge oclk) begin
    if (RST) begin
      state_q   <= S_RST;
      credits_q <= C_START;
      cnt_q     <= '0;
      lp_q      <= '0;
      dig_q     <= '0;
      rej_q     <= 1'b0;
      w4_q      <= 1'b0;
      w3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      lp_q      <= lp_d;
      dig_q     <= dig_d;
      rej_q     <= rej_d;
      w4_q      <= w4_d;
      w3_q      <= w3_d;
    end
  end

  assign credits     = credits_q;
  assign last_payout = lp_q;
  assign armed       = (state_q == S_ARMED);
  assign busy        = (state_q == S_PAY);
  assign broke       = (state_q == S_BROKE);
  assign reject      = rej_q;
  assign win4        = w4_q;
  assign win3        = w3_q;

endmodule
